// File: rtl/linked_list_pop_sched.sv
// Round-robin pop scheduler for the shared linked-list FIFO.
// Pops into a 2-entry output buffer; can also drain a queue to empty.
module linked_list_pop_sched #(
   parameter int WIDTH     = 4,
   parameter int NUM_FIFOS = 2,
   parameter int SEL_WIDTH = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_FIFOS-1:0] fifo_empty,
   input  logic [WIDTH-1:0]     fifo_data,
   output logic                 fifo_pop,
   output logic [SEL_WIDTH-1:0] fifo_pop_sel,
   input  logic [NUM_FIFOS-1:0] queue_en,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SEL_WIDTH-1:0] out_sel,
   input  logic                 drain_req,
   input  logic [SEL_WIDTH-1:0] drain_sel,
   output logic                 drain_done,
   output logic                 busy
);

   typedef enum logic {
      RUN,
      DRAIN
   } state_t;

   state_t state, state_nx;

   logic [SEL_WIDTH-1:0] rr_ptr;
   logic [SEL_WIDTH-1:0] rr_nx;
   logic [SEL_WIDTH-1:0] dq;
   logic [SEL_WIDTH-1:0] cand;
   logic                 found;
   logic [NUM_FIFOS-1:0] elig;
   logic                 dq_empty;

   logic [1:0]           cnt;
   logic [WIDTH-1:0]     bd [2];
   logic [SEL_WIDTH-1:0] bs [2];
   logic                 rd_p;
   logic                 wr_p;
   logic                 fire;
   logic                 buf_wr;
   logic                 done_nx;

   assign elig      = ~fifo_empty & queue_en;
   assign out_valid = (cnt != 2'd0);
   assign fire      = out_valid & out_ready;
   assign out_data  = bd[rd_p];
   assign out_sel   = bs[rd_p];
   assign busy      = (state == DRAIN);

   // Two passes: queues at or above rr_ptr first, then the wrapped ones.
   always_comb begin
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         if (!found && elig[i] && SEL_WIDTH'(i) >= rr_ptr) begin
            found = 1'b1;
            cand  = SEL_WIDTH'(i);
         end
      end
      for (int i = 0; i < NUM_FIFOS; i++) begin
         if (!found && elig[i] && SEL_WIDTH'(i) < rr_ptr) begin
            found = 1'b1;
            cand  = SEL_WIDTH'(i);
         end
      end
   end

   always_comb begin
      rr_nx = cand + 1'b1;
      if (cand == SEL_WIDTH'(NUM_FIFOS - 1))
         rr_nx = '0;
   end

   // Out-of-range drain targets read as empty.
   always_comb begin
      dq_empty = 1'b1;
      for (int i = 0; i < NUM_FIFOS; i++) begin
         if (dq == SEL_WIDTH'(i))
            dq_empty = fifo_empty[i];
      end
   end

   always_comb begin
      state_nx     = state;
      fifo_pop     = 1'b0;
      fifo_pop_sel = '0;
      buf_wr       = 1'b0;
      done_nx      = 1'b0;
      case (state)
         RUN: begin
            if (found && (cnt != 2'd2 || fire)) begin
               fifo_pop     = 1'b1;
               fifo_pop_sel = cand;
               buf_wr       = 1'b1;
            end
            if (drain_req)
               state_nx = DRAIN;
         end
         DRAIN: begin
            if (!dq_empty) begin
               fifo_pop     = 1'b1;
               fifo_pop_sel = dq;
            end else begin
               state_nx = RUN;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= RUN;
         rr_ptr     <= '0;
         dq         <= '0;
         drain_done <= 1'b0;
      end else begin
         state      <= state_nx;
         drain_done <= done_nx;
         if (state == RUN && drain_req)
            dq <= drain_sel;
         if (buf_wr)
            rr_ptr <= rr_nx;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt   <= 2'd0;
         rd_p  <= 1'b0;
         wr_p  <= 1'b0;
         bd[0] <= '0;
         bd[1] <= '0;
         bs[0] <= '0;
         bs[1] <= '0;
      end else begin
         if (buf_wr) begin
            bd[wr_p] <= fifo_data;
            bs[wr_p] <= fifo_pop_sel;
            wr_p     <= ~wr_p;
         end
         if (fire)
            rd_p <= ~rd_p;
         cnt <= cnt + {1'b0, buf_wr} - {1'b0, fire};
      end
   end

endmodule

// File: tb/tb_linked_list_pop_sched.sv
// Directed bench for linked_list_pop_sched with a small two-queue
// FIFO model driving fifo_empty/fifo_data.
module tb_linked_list_pop_sched;

   logic       clk;
   logic       rst;
   logic [1:0] fifo_empty;
   logic [3:0] fifo_data;
   logic       fifo_pop;
   logic       fifo_pop_sel;
   logic [1:0] queue_en;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_data;
   logic       out_sel;
   logic       drain_req;
   logic       drain_sel;
   logic       drain_done;
   logic       busy;

   int total = 0;
   int bad   = 0;

   logic [3:0] d0 [32];
   logic [3:0] d1 [32];
   logic [4:0] h0 = '0, t0 = '0;
   logic [4:0] h1 = '0, t1 = '0;
   int         pops = 0;
   int         bad_pops = 0;
   int         p0;

   linked_list_pop_sched #(
      .WIDTH(4),
      .NUM_FIFOS(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fifo_empty(fifo_empty),
      .fifo_data(fifo_data),
      .fifo_pop(fifo_pop),
      .fifo_pop_sel(fifo_pop_sel),
      .queue_en(queue_en),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_sel(out_sel),
      .drain_req(drain_req),
      .drain_sel(drain_sel),
      .drain_done(drain_done),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_empty = {(t1 == h1), (t0 == h0)};
   assign fifo_data  = fifo_pop_sel ? d1[h1] : d0[h0];

   always @(posedge clk) begin
      if (fifo_pop) begin
         pops <= pops + 1;
         if (fifo_empty[fifo_pop_sel])
            bad_pops <= bad_pops + 1;
         else if (fifo_pop_sel)
            h1 <= h1 + 5'd1;
         else
            h0 <= h0 + 5'd1;
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push0(input logic [3:0] v);
      d0[t0] = v;
      t0 = t0 + 5'd1;
   endtask

   task automatic push1(input logic [3:0] v);
      d1[t1] = v;
      t1 = t1 + 5'd1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      queue_en = 2'b00;
      out_ready = 1'b0;
      drain_req = 1'b0;
      drain_sel = 1'b0;
      #1 rst = 1'b0;
      #11;
      chk("rst_valid", out_valid, 0);
      chk("rst_pop", fifo_pop, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", drain_done, 0);
      chk("rst_data", out_data, 0);
      chk("rst_sel", out_sel, 0);
      chk("rst_psel", fifo_pop_sel, 0);

      // round-robin alternation
      push0(4'h1); push0(4'h2); push0(4'h3);
      push1(4'h9); push1(4'hA); push1(4'hB);
      queue_en = 2'b11;
      out_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("rr0_pop", fifo_pop, 1);
      chk("rr0_sel", fifo_pop_sel, 0);
      step();
      chk("rr1_pop", fifo_pop, 1);
      chk("rr1_sel", fifo_pop_sel, 1);
      chk("rr1_osel", out_sel, 0);
      chk("rr1_odata", out_data, 4'h1);
      step();
      chk("rr2_pop", fifo_pop, 1);
      chk("rr2_sel", fifo_pop_sel, 0);
      chk("rr2_osel", out_sel, 1);
      chk("rr2_odata", out_data, 4'h9);
      step();
      chk("rr3_sel", fifo_pop_sel, 1);
      chk("rr3_osel", out_sel, 0);
      chk("rr3_odata", out_data, 4'h2);
      queue_en = 2'b00;
      step();
      chk("rr_idle_valid", out_valid, 0);
      chk("rr_idle_pop", fifo_pop, 0);

      // backpressure: q0 holds 3,4,5
      push0(4'h4); push0(4'h5);
      out_ready = 1'b0;
      queue_en = 2'b01;
      p0 = pops;
      step(); step(); step();
      chk("bp_pops", pops - p0, 2);
      chk("bp_pop_stall", fifo_pop, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_headA", out_data, 4'h3);
      step();
      chk("bp_hold", out_data, 4'h3);
      out_ready = 1'b1;
      #1;
      chk("bp_fire_pop", fifo_pop, 1);
      step();
      chk("bp_headB", out_data, 4'h4);
      step();
      chk("bp_headC", out_data, 4'h5);
      step();
      chk("bp_empty", out_valid, 0);

      // only queue 1 enabled
      push0(4'h6);
      queue_en = 2'b10;
      #1;
      chk("en_pop", fifo_pop, 1);
      chk("en_sel", fifo_pop_sel, 1);
      step();
      chk("en_sel2", fifo_pop_sel, 1);
      chk("en_data", out_data, 4'hA);
      chk("en_osel", out_sel, 1);
      step();
      chk("en_nopop", fifo_pop, 0);
      chk("en_data2", out_data, 4'hB);
      step();
      chk("en_valid0", out_valid, 0);
      chk("en_q0_kept", 32'(t0 - h0), 1);

      // drain queue 1 holding 3 words
      push1(4'hC); push1(4'hD); push1(4'hE);
      queue_en = 2'b00;
      drain_req = 1'b1;
      drain_sel = 1'b1;
      #1;
      chk("dr_req_nopop", fifo_pop, 0);
      p0 = pops;
      step();
      drain_req = 1'b0;
      chk("dr_busy", busy, 1);
      for (int i = 0; i < 3; i++) begin
         chk("dr_pop", fifo_pop, 1);
         chk("dr_sel", fifo_pop_sel, 1);
         step();
      end
      chk("dr_pops", pops - p0, 3);
      chk("dr_end_pop", fifo_pop, 0);
      chk("dr_end_busy", busy, 1);
      chk("dr_no_buf", out_valid, 0);
      chk("dr_q0_kept", 32'(t0 - h0), 1);
      step();
      chk("dr_done", drain_done, 1);
      chk("dr_run", busy, 0);
      step();
      chk("dr_done_pulse", drain_done, 0);

      // empty q0, then drain it
      queue_en = 2'b01;
      #1;
      chk("clr_pop", fifo_pop, 1);
      step();
      queue_en = 2'b00;
      step();
      chk("clr_empty", fifo_empty, 2'b11);
      drain_req = 1'b1;
      drain_sel = 1'b0;
      p0 = pops;
      step();
      drain_req = 1'b0;
      chk("de_busy", busy, 1);
      chk("de_nodone", drain_done, 0);
      chk("de_nopop", fifo_pop, 0);
      step();
      chk("de_done", drain_done, 1);
      chk("de_idle", busy, 0);
      chk("de_pops", pops - p0, 0);

      // async reset mid-drain with one buffered word
      push0(4'h7);
      push1(4'h1); push1(4'h2); push1(4'h3);
      out_ready = 1'b0;
      queue_en = 2'b01;
      step();
      queue_en = 2'b00;
      drain_req = 1'b1;
      drain_sel = 1'b1;
      step();
      drain_req = 1'b0;
      chk("ar_busy", busy, 1);
      chk("ar_pop", fifo_pop, 1);
      chk("ar_valid", out_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("ar_valid0", out_valid, 0);
      chk("ar_pop0", fifo_pop, 0);
      chk("ar_busy0", busy, 0);
      chk("ar_done0", drain_done, 0);
      #3;
      chk("ar_q1_intact", 32'(t1 - h1), 3);
      push0(4'h8);
      queue_en = 2'b11;
      out_ready = 1'b1;
      rst = 1'b1;
      #1;
      chk("ar_rr_pop", fifo_pop, 1);
      chk("ar_rr_sel", fifo_pop_sel, 0);
      step();
      chk("ar_rr_sel2", fifo_pop_sel, 1);
      chk("ar_odata", out_data, 4'h8);
      chk("ar_osel", out_sel, 0);

      chk("no_empty_pop", bad_pops, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
